// File: rtl/axis_i2c_cmd_seq_pkg.sv
// Shared types and constants for the I2C command sequencer.
//   - AXIS word layout: [7:0] = {RW, slave addr[6:0]}, [15:8] = data byte.
//   - i2c_cmd_t: one table entry (post-delay in ms plus the AXIS word).
//   - seq_state_e: sequencer FSM states.
//   - cmd_table(): table contents; edit this to retarget the init sequence.
package axis_i2c_cmd_seq_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 16;
  localparam int unsigned I2C_RW_BIT      = 7;
  localparam logic        I2C_WRITE       = 1'b0;
  localparam int unsigned CMD_DELAY_WIDTH = 8;

  typedef struct packed {
    logic [CMD_DELAY_WIDTH-1:0] delay;
    logic [AXIS_DATA_WIDTH-1:0] word;
  } i2c_cmd_t;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StSend  = 3'd2,
    StDelay = 3'd3,
    StDone  = 3'd4
  } seq_state_e;

  function automatic i2c_cmd_t cmd_table(input int unsigned idx);
    i2c_cmd_t cmd;
    cmd.delay = '0;
    cmd.word  = '0;
    case (idx)
      0: begin cmd.word = 16'h011A; cmd.delay = CMD_DELAY_WIDTH'(0); end
      1: begin cmd.word = 16'h801A; cmd.delay = CMD_DELAY_WIDTH'(2); end
      2: begin cmd.word = 16'hFF3C; cmd.delay = CMD_DELAY_WIDTH'(0); end
      // Written as a read; the sequencer only ever issues writes.
      3: begin cmd.word = 16'h55B0; cmd.delay = CMD_DELAY_WIDTH'(1); end
      default: begin cmd.word = {8'(idx), 8'h20}; cmd.delay = '0; end
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/axis_i2c_cmd_seq_if.sv
// AXI-Stream command channel from the sequencer to the I2C master.
//   tdata  : 16-bit command word
//   tvalid : command valid (master -> slave)
//   tready : command accepted (slave -> master)
interface axis_i2c_cmd_seq_if import axis_i2c_cmd_seq_pkg::*; ();

  logic [AXIS_DATA_WIDTH-1:0] tdata;
  logic                       tvalid;
  logic                       tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_i2c_cmd_seq_rom.sv
// Constant command table with a registered read port.
//   clk_i, arstn_i : clock, async active-low reset (output register clears to 0)
//   rd_en_i        : load entry addr_i into the output register
//   addr_i         : table index
//   cmd_o          : registered entry, held while rd_en_i is low
module axis_i2c_cmd_seq_rom import axis_i2c_cmd_seq_pkg::*; #(
  parameter int unsigned NUM_CMDS = 16,
  parameter int unsigned IdxW     = 4
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            rd_en_i,
  input  logic [IdxW-1:0] addr_i,
  output i2c_cmd_t        cmd_o
);

  i2c_cmd_t cmd_q, cmd_d;

  always_comb begin
    cmd_d = cmd_q;
    // Index width rounds up to a power of two; never read past the table.
    if (rd_en_i && (32'(addr_i) < NUM_CMDS)) begin
      cmd_d = cmd_table(32'(addr_i));
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= cmd_d;
    end
  end

  assign cmd_o = cmd_q;

endmodule

// File: rtl/axis_i2c_cmd_seq.sv
// Walks the constant I2C command table after reset (AUTO_START) or on start_i and
// emits one AXIS word per entry, waiting the entry's post-delay (ms) after each.
//   clk_i, arstn_i : clock, async active-low reset
//   start_i        : 1-cycle pulse, (re)run the table; ignored while busy_o
//   m_axis         : command stream (master modport)
//   busy_o         : sequence in progress
//   done_o         : sticky, last sequence completed; cleared by an accepted start
module axis_i2c_cmd_seq import axis_i2c_cmd_seq_pkg::*; #(
  parameter int unsigned NUM_CMDS   = 16,
  parameter int unsigned DELAY_W    = CMD_DELAY_WIDTH,
  parameter int unsigned TICK_DIV   = 100_000,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  input  logic               start_i,
  axis_i2c_cmd_seq_if.master m_axis,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned IdxW  = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(NUM_CMDS - 1);
  localparam logic [TickW-1:0] LastTick = TickW'(TICK_DIV - 1);

  seq_state_e                 state_q, state_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [TickW-1:0]           tick_q, tick_d;
  logic [DELAY_W-1:0]         ms_q, ms_d;
  logic                       auto_q, auto_d;
  logic                       done_q, done_d;
  logic                       rom_rd;
  i2c_cmd_t                   cmd;
  logic [DELAY_W-1:0]         delay;
  logic                       delay_end;
  logic [AXIS_DATA_WIDTH-1:0] word_out;

  axis_i2c_cmd_seq_rom #(
    .NUM_CMDS (NUM_CMDS),
    .IdxW     (IdxW)
  ) u_rom (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .rd_en_i (rom_rd),
    .addr_i  (idx_q),
    .cmd_o   (cmd)
  );

  assign delay = DELAY_W'(cmd.delay);
  // Zero delay spends one cycle in StDelay; otherwise exactly delay*TICK_DIV cycles.
  assign delay_end = (delay == '0) ||
                     ((ms_q == delay - DELAY_W'(1)) && (tick_q == LastTick));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tick_d  = tick_q;
    ms_d    = ms_q;
    auto_d  = auto_q;
    done_d  = done_q;
    rom_rd  = 1'b0;
    unique case (state_q)
      // StDone lasts one cycle and behaves like StIdle, so a start there is taken.
      StIdle, StDone: begin
        state_d = StIdle;
        if (start_i || auto_q) begin
          state_d = StFetch;
          idx_d   = '0;
          auto_d  = 1'b0;
          done_d  = 1'b0;
        end
      end
      StFetch: begin
        rom_rd  = 1'b1;
        state_d = StSend;
      end
      StSend: begin
        if (m_axis.tready) begin
          state_d = StDelay;
          tick_d  = '0;
          ms_d    = '0;
        end
      end
      StDelay: begin
        if (delay_end) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
            done_d  = 1'b1;
          end else begin
            state_d = StFetch;
            idx_d   = idx_q + 1'b1;
          end
        end else if (tick_q == LastTick) begin
          tick_d = '0;
          ms_d   = ms_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tick_q  <= '0;
      ms_q    <= '0;
      auto_q  <= AUTO_START;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      ms_q    <= ms_d;
      auto_q  <= auto_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    word_out             = cmd.word;
    word_out[I2C_RW_BIT] = I2C_WRITE;
  end

  assign m_axis.tdata  = word_out;
  assign m_axis.tvalid = (state_q == StSend);
  assign busy_o        = state_q inside {StFetch, StSend, StDelay};
  assign done_o        = done_q;

endmodule
